// File: rtl/piso_serializer.sv
// -----------------------------------------------------------------------------
// piso_serializer
//
// Parallel-in / serial-out transmitter feeding the serial input of a
// serial-in shift register receiver. A WIDTH-bit word is taken over a
// valid/ready handshake into a one-entry holding buffer, then shifted out one
// bit per clock. data_in[WIDTH-1] goes first and data_in[0] goes last. The
// receiver shifts toward higher indices, so its Q[0:WIDTH-1] ends up equal to
// the word. When a word is already waiting, frames stream back-to-back with no
// idle cycle between them.
//
// Ports
//   clk         rising-edge clock, shared with the receiver
//   rst_n       asynchronous active-low reset
//   load_valid  a word on data_in is offered this cycle
//   load_ready  holding buffer empty; a word can be accepted
//   data_in     parallel word [0:WIDTH-1]; index 0 is the leftmost receiver stage
//   ser_out     serial bit (registered)
//   ser_en      ser_out carries a valid frame bit (registered)
//   frame_last  ser_out carries the last bit of the frame (registered)
// -----------------------------------------------------------------------------
module piso_serializer #(
  parameter int unsigned WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             load_valid,
  output logic             load_ready,
  input  logic [0:WIDTH-1] data_in,
  output logic             ser_out,
  output logic             ser_en,
  output logic             frame_last
);

  localparam int unsigned     CW       = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CW-1:0]   LAST_CNT = CW'(WIDTH - 1);

  typedef enum logic {
    IDLE  = 1'b0,
    SHIFT = 1'b1
  } state_t;

  state_t           state_r;
  logic [0:WIDTH-1] hold_r;
  logic             hold_full_r;
  logic [0:WIDTH-1] sh_r;
  logic [CW-1:0]    cnt_r;
  logic             ser_out_r;
  logic             ser_en_r;
  logic             frame_last_r;

  logic             accept_s;
  logic [CW-1:0]    cnt_inc_s;
  logic [CW-1:0]    idx_s;

  // Handshake and the shifter index of the bit presented after the next edge.
  // The outputs are registered, so at each edge they are loaded with the bit
  // that belongs to the incremented count.
  always_comb begin
    accept_s  = load_valid && !hold_full_r;
    cnt_inc_s = cnt_r + CW'(1);
    idx_s     = LAST_CNT - cnt_inc_s;
  end

  // load_ready is a pure function of the buffer flag; no path from load_valid.
  assign load_ready = !hold_full_r;
  assign ser_out    = ser_out_r;
  assign ser_en     = ser_en_r;
  assign frame_last = frame_last_r;

  // Holding buffer, frame FSM, bit counter and registered serial outputs.
  // An accept and a hold-to-shifter transfer are mutually exclusive:
  // accept needs hold_full_r low, transfer needs it high.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r      <= IDLE;
      hold_r       <= '0;
      hold_full_r  <= 1'b0;
      sh_r         <= '0;
      cnt_r        <= '0;
      ser_out_r    <= 1'b0;
      ser_en_r     <= 1'b0;
      frame_last_r <= 1'b0;
    end else begin
      if (accept_s) begin
        hold_r      <= data_in;
        hold_full_r <= 1'b1;
      end

      case (state_r)
        IDLE: begin
          if (hold_full_r) begin
            sh_r         <= hold_r;
            hold_full_r  <= 1'b0;
            cnt_r        <= '0;
            state_r      <= SHIFT;
            ser_en_r     <= 1'b1;
            ser_out_r    <= hold_r[WIDTH-1];
            frame_last_r <= 1'b0;
          end else begin
            ser_en_r     <= 1'b0;
            ser_out_r    <= 1'b0;
            frame_last_r <= 1'b0;
          end
        end

        SHIFT: begin
          if (cnt_r != LAST_CNT) begin
            cnt_r        <= cnt_inc_s;
            ser_en_r     <= 1'b1;
            ser_out_r    <= sh_r[idx_s];
            frame_last_r <= (cnt_inc_s == LAST_CNT);
          end else if (hold_full_r) begin
            // Gapless streaming: the next frame's first bit follows the last.
            sh_r         <= hold_r;
            hold_full_r  <= 1'b0;
            cnt_r        <= '0;
            ser_en_r     <= 1'b1;
            ser_out_r    <= hold_r[WIDTH-1];
            frame_last_r <= 1'b0;
          end else begin
            state_r      <= IDLE;
            cnt_r        <= '0;
            ser_en_r     <= 1'b0;
            ser_out_r    <= 1'b0;
            frame_last_r <= 1'b0;
          end
        end

        default: begin
          state_r      <= IDLE;
          cnt_r        <= '0;
          ser_en_r     <= 1'b0;
          ser_out_r    <= 1'b0;
          frame_last_r <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_piso_serializer.sv
// -----------------------------------------------------------------------------
// tb_piso_serializer
//
// Drives a WIDTH=4 and a WIDTH=2 instance side by side. Each instance's
// behaviour is predicted from frame start times. A word accepted at edge a
// starts at s = max(a+1, previous_start+WIDTH). After edge s+o it shows bit o
// of the word value, i.e. data_in[WIDTH-1-o]. The buffer is busy while any
// frame start lies in the future. A model receiver shift register is fed by
// each ser_out.
// -----------------------------------------------------------------------------
module tb_piso_serializer;

  logic       clk;
  logic       rst_n;
  logic       lv4, lv2;
  logic [0:3] d4;
  logic [0:1] d2;
  logic       rdy4, out4, en4, last4;
  logic       rdy2, out2, en2, last2;
  logic [0:3] rx4;
  logic [0:1] rx2;

  int n_checks = 0;
  int n_pass   = 0;

  // reference model state, per instance (0: WIDTH=4, 1: WIDTH=2)
  int          t;
  int          wd[2];
  int          ls[2];
  int          ps[2];
  logic [15:0] lw[2];
  logic [15:0] pw[2];

  piso_serializer #(.WIDTH(4)) dut4 (
    .clk(clk), .rst_n(rst_n), .load_valid(lv4), .load_ready(rdy4),
    .data_in(d4), .ser_out(out4), .ser_en(en4), .frame_last(last4)
  );

  piso_serializer #(.WIDTH(2)) dut2 (
    .clk(clk), .rst_n(rst_n), .load_valid(lv2), .load_ready(rdy2),
    .data_in(d2), .ser_out(out2), .ser_en(en2), .frame_last(last2)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // receivers: plain serial-in shift registers clocked every cycle
  always @(posedge clk) begin
    rx4 <= {out4, rx4[0:2]};
    rx2 <= {out2, rx2[0]};
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout required completion");
    $fatal(1);
  end

  task automatic chk(input string nm, input logic [15:0] act, input logic [15:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s @t=%0d: actual %0h required %0h", nm, t, act, exp);
  endtask

  task automatic m_reset();
    for (int i = 0; i < 2; i++) begin
      ls[i] = -1000; ps[i] = -1000; lw[i] = 16'd0; pw[i] = 16'd0;
    end
  endtask

  function automatic bit m_rdy(input int i);
    return !(ls[i] > t);
  endfunction

  // Compare one instance against the frame-timing model after the current edge.
  task automatic check_inst(input int i);
    logic e_en, e_out, e_last;
    logic a_en, a_out, a_last, a_rdy;
    logic [15:0] a_rx;
    string p;
    e_en = 1'b0; e_out = 1'b0; e_last = 1'b0;
    if (t >= ls[i] && t <= ls[i] + wd[i] - 1) begin
      e_en = 1'b1; e_out = lw[i][t - ls[i]]; e_last = (t == ls[i] + wd[i] - 1);
    end else if (t >= ps[i] && t <= ps[i] + wd[i] - 1) begin
      e_en = 1'b1; e_out = pw[i][t - ps[i]]; e_last = (t == ps[i] + wd[i] - 1);
    end
    if (i == 0) begin
      a_en = en4; a_out = out4; a_last = last4; a_rdy = rdy4; a_rx = 16'(rx4); p = "w4";
    end else begin
      a_en = en2; a_out = out2; a_last = last2; a_rdy = rdy2; a_rx = 16'(rx2); p = "w2";
    end
    chk({p, " ser_en"},     16'(a_en),   16'(e_en));
    chk({p, " ser_out"},    16'(a_out),  16'(e_out));
    chk({p, " frame_last"}, 16'(a_last), 16'(e_last));
    chk({p, " load_ready"}, 16'(a_rdy),  16'(m_rdy(i)));
    // receiver holds the word one edge after the frame's last bit
    if (t == ls[i] + wd[i]) chk({p, " rx_q"}, a_rx, lw[i]);
    else if (t == ps[i] + wd[i]) chk({p, " rx_q"}, a_rx, pw[i]);
  endtask

  // One clock: decide accepts from the model, advance it, then check both DUTs.
  task automatic step();
    bit          acc[2];
    logic [15:0] w[2];
    int          s;
    acc[0] = lv4 && m_rdy(0); w[0] = {12'd0, d4};
    acc[1] = lv2 && m_rdy(1); w[1] = {14'd0, d2};
    @(posedge clk);
    t = t + 1;
    for (int i = 0; i < 2; i++) begin
      if (acc[i]) begin
        s = (t + 1 > ls[i] + wd[i]) ? t + 1 : ls[i] + wd[i];
        ps[i] = ls[i]; pw[i] = lw[i];
        ls[i] = s;     lw[i] = w[i];
      end
    end
    #1;
    check_inst(0);
    check_inst(1);
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk({tag, " w4 ser_en"},     16'(en4),   16'd0);
    chk({tag, " w4 ser_out"},    16'(out4),  16'd0);
    chk({tag, " w4 frame_last"}, 16'(last4), 16'd0);
    chk({tag, " w4 load_ready"}, 16'(rdy4),  16'd1);
    chk({tag, " w2 ser_en"},     16'(en2),   16'd0);
    chk({tag, " w2 ser_out"},    16'(out2),  16'd0);
    chk({tag, " w2 frame_last"}, 16'(last2), 16'd0);
    chk({tag, " w2 load_ready"}, 16'(rdy2),  16'd1);
  endtask

  typedef struct {
    logic       lv;
    logic [3:0] d;
    logic       e_en;
    logic       e_out;
    logic       e_last;
    logic       e_rdy;
  } vec_t;

  vec_t tbl[26];
  int   pat[4];

  initial begin
    // single word 1011: bits 1,1,0,1
    tbl[0]  = '{1'b1, 4'b1011, 1'b0, 1'b0, 1'b0, 1'b0};
    tbl[1]  = '{1'b0, 4'b0000, 1'b1, 1'b1, 1'b0, 1'b1};
    tbl[2]  = '{1'b0, 4'b0000, 1'b1, 1'b1, 1'b0, 1'b1};
    tbl[3]  = '{1'b0, 4'b0000, 1'b1, 1'b0, 1'b0, 1'b1};
    tbl[4]  = '{1'b0, 4'b0000, 1'b1, 1'b1, 1'b1, 1'b1};
    tbl[5]  = '{1'b0, 4'b0000, 1'b0, 1'b0, 1'b0, 1'b1};
    // back-to-back 0001 then 1110 with load_valid held high
    tbl[6]  = '{1'b1, 4'b0001, 1'b0, 1'b0, 1'b0, 1'b0};
    tbl[7]  = '{1'b1, 4'b1110, 1'b1, 1'b1, 1'b0, 1'b1};
    tbl[8]  = '{1'b1, 4'b1110, 1'b1, 1'b0, 1'b0, 1'b0};
    tbl[9]  = '{1'b0, 4'b0000, 1'b1, 1'b0, 1'b0, 1'b0};
    tbl[10] = '{1'b0, 4'b0000, 1'b1, 1'b0, 1'b1, 1'b0};
    tbl[11] = '{1'b0, 4'b0000, 1'b1, 1'b0, 1'b0, 1'b1};
    tbl[12] = '{1'b0, 4'b0000, 1'b1, 1'b1, 1'b0, 1'b1};
    tbl[13] = '{1'b0, 4'b0000, 1'b1, 1'b1, 1'b0, 1'b1};
    tbl[14] = '{1'b0, 4'b0000, 1'b1, 1'b1, 1'b1, 1'b1};
    tbl[15] = '{1'b0, 4'b0000, 1'b0, 1'b0, 1'b0, 1'b1};
    // backpressure: data changes while not ready; only 0110 and 1001 are sent
    tbl[16] = '{1'b1, 4'b0110, 1'b0, 1'b0, 1'b0, 1'b0};
    tbl[17] = '{1'b1, 4'b1111, 1'b1, 1'b0, 1'b0, 1'b1};
    tbl[18] = '{1'b1, 4'b1001, 1'b1, 1'b1, 1'b0, 1'b0};
    tbl[19] = '{1'b1, 4'b0000, 1'b1, 1'b1, 1'b0, 1'b0};
    tbl[20] = '{1'b0, 4'b0000, 1'b1, 1'b0, 1'b1, 1'b0};
    tbl[21] = '{1'b0, 4'b0000, 1'b1, 1'b1, 1'b0, 1'b1};
    tbl[22] = '{1'b0, 4'b0000, 1'b1, 1'b0, 1'b0, 1'b1};
    tbl[23] = '{1'b0, 4'b0000, 1'b1, 1'b0, 1'b0, 1'b1};
    tbl[24] = '{1'b0, 4'b0000, 1'b1, 1'b1, 1'b1, 1'b1};
    tbl[25] = '{1'b0, 4'b0000, 1'b0, 1'b0, 1'b0, 1'b1};
    pat = '{1, 0, 0, 1};

    wd[0] = 4; wd[1] = 2; t = 0;
    m_reset();
    rst_n = 1'b0; lv4 = 1'b0; lv2 = 1'b0; d4 = 4'b0000; d2 = 2'b00;
    #2;
    chk_reset_outputs("por");
    @(negedge clk);
    rst_n = 1'b1;

    // directed table on the WIDTH=4 instance
    for (int r = 0; r < 26; r++) begin
      lv4 = tbl[r].lv; d4 = tbl[r].d;
      step();
      chk($sformatf("tbl[%0d] ser_en", r),     16'(en4),   16'(tbl[r].e_en));
      chk($sformatf("tbl[%0d] ser_out", r),    16'(out4),  16'(tbl[r].e_out));
      chk($sformatf("tbl[%0d] frame_last", r), 16'(last4), 16'(tbl[r].e_last));
      chk($sformatf("tbl[%0d] load_ready", r), 16'(rdy4),  16'(tbl[r].e_rdy));
    end
    lv4 = 1'b0;

    // reset mid-frame with a second word buffered
    lv4 = 1'b1; d4 = 4'b1010; step();
    d4 = 4'b0101; step();
    step();
    lv4 = 1'b0; step();
    chk("pre-reset w4 busy", 16'(en4), 16'd1);
    #2 rst_n = 1'b0;
    #1;
    chk_reset_outputs("midrst");
    m_reset();
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    chk_reset_outputs("release");
    for (int k = 0; k < 6; k++) begin
      step();
      chk("post-reset no residue", 16'(en4), 16'd0);
    end

    // WIDTH=2 continuous stream of 01/10
    lv2 = 1'b1; d2 = 2'b01;
    step();
    d2 = 2'b10;
    for (int k = 1; k <= 16; k++) begin
      bit a;
      a = m_rdy(1);
      step();
      chk($sformatf("w2 stream[%0d] ser_en", k),     16'(en2),   16'd1);
      chk($sformatf("w2 stream[%0d] ser_out", k),    16'(out2),  16'(pat[(k - 1) % 4]));
      chk($sformatf("w2 stream[%0d] frame_last", k), 16'(last2), 16'((k % 2) == 0));
      if (a) d2 = (d2 == 2'b01) ? 2'b10 : 2'b01;
    end
    lv2 = 1'b0;
    for (int k = 0; k < 4; k++) step();

    // randomized traffic on both instances; the source holds a word until taken
    for (int k = 0; k < 400; k++) begin
      bit a4, a2;
      a4 = lv4 && m_rdy(0);
      a2 = lv2 && m_rdy(1);
      if (!lv4 || a4) begin
        lv4 = ($urandom_range(0, 99) < 65);
        d4  = 4'($urandom);
      end
      if (!lv2 || a2) begin
        lv2 = ($urandom_range(0, 99) < 65);
        d2  = 2'($urandom);
      end
      step();
    end
    lv4 = 1'b0; lv2 = 1'b0;
    for (int k = 0; k < 10; k++) step();

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
